// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default,
// initiator FSM states and peripheral address map constants.
package axi_lite_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access
    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    // Peripheral map
    localparam logic [31:0] UART_BASE_ADDR     = 32'h2000_0000;
    localparam logic [31:0] PERIPH_WINDOW_MASK = 32'h0FFF_FFFF;

    // Initiator FSM states
    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } axi_state_e;

    // A request hits when the non-offset bits match the window base
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] mask);
        return (addr & ~mask) == base;
    endfunction

    // Anything other than OKAY is reported to the core as an error
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            RESP_OKAY:                err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            RESP_EXOKAY:              err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: converts the core load/store request port into
// single outstanding AXI4-Lite transactions. Requests outside the
// peripheral window are answered locally with an error.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = UART_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK = PERIPH_WINDOW_MASK
) (
    input  logic        m_axi_aclk_i,
    input  logic        m_axi_aresetn_i,

    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wstrb_i,

    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,

    output logic [31:0] m_axi_awaddr_o,
    output logic [2:0]  m_axi_awprot_o,
    output logic        m_axi_awvalid_o,
    input  logic        m_axi_awready_i,

    output logic [31:0] m_axi_wdata_o,
    output logic [3:0]  m_axi_wstrb_o,
    output logic        m_axi_wvalid_o,
    input  logic        m_axi_wready_i,

    input  logic [1:0]  m_axi_bresp_i,
    input  logic        m_axi_bvalid_i,
    output logic        m_axi_bready_o,

    output logic [31:0] m_axi_araddr_o,
    output logic [2:0]  m_axi_arprot_o,
    output logic        m_axi_arvalid_o,
    input  logic        m_axi_arready_i,

    input  logic [31:0] m_axi_rdata_i,
    input  logic [1:0]  m_axi_rresp_i,
    input  logic        m_axi_rvalid_i,
    output logic        m_axi_rready_o
);

    axi_state_e  state_q;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        awvalid_q;
    logic        wvalid_q;
    logic        arvalid_q;
    logic        bready_q;
    logic        rready_q;

    logic        aw_done_q;
    logic        w_done_q;

    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        req_hit;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_done_d;
    logic        w_done_d;

    // Handshake and window decode helpers
    always_comb begin
        req_hit   = addr_in_window(req_addr_i, ADDR_BASE, ADDR_MASK);
        aw_hs     = awvalid_q & m_axi_awready_i;
        w_hs      = wvalid_q & m_axi_wready_i;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
    end

    // Transaction FSM with registered AXI and response outputs
    always_ff @(posedge m_axi_aclk_i or negedge m_axi_aresetn_i) begin
        if (!m_axi_aresetn_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        wstrb_q <= req_wstrb_i;
                        if (!req_hit) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (req_write_i) begin
                            state_q   <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                WR: begin
                    // AW and W complete independently; leave as soon as the
                    // later of the two handshakes is seen
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                    end
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        state_q   <= WR_RESP;
                        bready_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end

                WR_RESP: begin
                    if (m_axi_bvalid_i) begin
                        bready_q    <= 1'b0;
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= resp_is_error(m_axi_bresp_i);
                        rsp_rdata_q <= '0;
                    end
                end

                RD_ADDR: begin
                    if (m_axi_arready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (m_axi_rvalid_i) begin
                        rready_q    <= 1'b0;
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= resp_is_error(m_axi_rresp_i);
                        rsp_rdata_q <= m_axi_rdata_i;
                    end
                end

                RESP: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        req_ready_o     = (state_q == IDLE) & m_axi_aresetn_i;

        rsp_valid_o     = rsp_valid_q;
        rsp_rdata_o     = rsp_rdata_q;
        rsp_err_o       = rsp_err_q;

        m_axi_awaddr_o  = addr_q;
        m_axi_awprot_o  = PROT_DEFAULT;
        m_axi_awvalid_o = awvalid_q;

        m_axi_wdata_o   = wdata_q;
        m_axi_wstrb_o   = wstrb_q;
        m_axi_wvalid_o  = wvalid_q;

        m_axi_bready_o  = bready_q;

        m_axi_araddr_o  = addr_q;
        m_axi_arprot_o  = PROT_DEFAULT;
        m_axi_arvalid_o = arvalid_q;

        m_axi_rready_o  = rready_q;
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a delay-configurable AXI4-Lite
// slave model and a response scoreboard.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    logic [31:0] awaddr_o;
    logic [2:0]  awprot_o;
    logic        awvalid_o;
    logic        awready = 1'b0;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wvalid_o;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready_o;
    logic [31:0] araddr_o;
    logic [2:0]  arprot_o;
    logic        arvalid_o;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready_o;

    axi_lite_master #(
        .ADDR_BASE(32'h2000_0000),
        .ADDR_MASK(32'h0FFF_FFFF)
    ) dut (
        .m_axi_aclk_i   (clk),
        .m_axi_aresetn_i(rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_wstrb_i    (req_wstrb),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .m_axi_awaddr_o (awaddr_o),
        .m_axi_awprot_o (awprot_o),
        .m_axi_awvalid_o(awvalid_o),
        .m_axi_awready_i(awready),
        .m_axi_wdata_o  (wdata_o),
        .m_axi_wstrb_o  (wstrb_o),
        .m_axi_wvalid_o (wvalid_o),
        .m_axi_wready_i (wready),
        .m_axi_bresp_i  (bresp),
        .m_axi_bvalid_i (bvalid),
        .m_axi_bready_o (bready_o),
        .m_axi_araddr_o (araddr_o),
        .m_axi_arprot_o (arprot_o),
        .m_axi_arvalid_o(arvalid_o),
        .m_axi_arready_i(arready),
        .m_axi_rdata_i  (rdata),
        .m_axi_rresp_i  (rresp),
        .m_axi_rvalid_i (rvalid),
        .m_axi_rready_o (rready_o)
    );

    always #5 clk = ~clk;

    // Slave configuration, written by the stimulus
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    // Slave observations, written only by the slave process
    int          cyc = 0;
    int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, b_hs_cyc = 0, ar_hs_cyc = 0;
    int          aw_vld_n = 0, w_vld_n = 0, ar_vld_n = 0;
    int          w_after = 0, aw_after = 0, aw_unstable = 0;
    logic [31:0] aw_addr_seen = '0, w_data_seen = '0, ar_addr_seen = '0;
    logic [3:0]  w_strb_seen = '0;

    // Slave model: samples at the rising edge, drives at the falling edge
    always begin : slave
        bit          aw_got, w_got, b_pend, r_pend, aw_track;
        int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        logic [31:0] aw_first;
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_track = 0;
        end else begin
            if (awvalid_o) aw_vld_n++;
            if (wvalid_o) w_vld_n++;
            if (arvalid_o) ar_vld_n++;
            if (wvalid_o && w_got) w_after++;
            if (awvalid_o && aw_got) aw_after++;
            if (awvalid_o) begin
                if (!aw_track) begin
                    aw_first = awaddr_o; aw_track = 1;
                end else if (awaddr_o !== aw_first) begin
                    aw_unstable++;
                end
            end
            if (awvalid_o && awready) begin
                aw_hs_n++; aw_hs_cyc = cyc; aw_addr_seen = awaddr_o;
                aw_got = 1; aw_track = 0;
            end
            if (wvalid_o && wready) begin
                w_hs_n++; w_hs_cyc = cyc; w_data_seen = wdata_o;
                w_strb_seen = wstrb_o; w_got = 1;
            end
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
            end
            if (bvalid && bready_o) begin
                b_hs_n++; b_hs_cyc = cyc; b_pend = 0;
            end
            if (arvalid_o && arready) begin
                ar_hs_n++; ar_hs_cyc = cyc; ar_addr_seen = araddr_o;
                r_pend = 1; r_cnt = 0;
            end
            if (rvalid && rready_o) begin
                r_hs_n++; r_pend = 0;
            end
        end
        @(negedge clk);
        if (!rst_n) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            awready = awvalid_o && (aw_cnt >= aw_dly);
            aw_cnt  = awvalid_o ? aw_cnt + 1 : 0;
            wready  = wvalid_o && (w_cnt >= w_dly);
            w_cnt   = wvalid_o ? w_cnt + 1 : 0;
            arready = arvalid_o && (ar_cnt >= ar_dly);
            ar_cnt  = arvalid_o ? ar_cnt + 1 : 0;
            bvalid  = b_pend && (b_cnt >= b_dly);
            bresp   = bresp_cfg;
            if (b_pend) b_cnt++;
            rvalid  = r_pend && (r_cnt >= r_dly);
            rdata   = r_pend ? rdata_cfg : 32'h0;
            rresp   = rresp_cfg;
            if (r_pend) r_cnt++;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          rel;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request and wait (bounded) for its acceptance edge
    task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        bit got = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr;
        req_wdata = data; req_wstrb = strb;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_ready_o === 1'b1) got = 1;
            else @(negedge clk);
        end
        check({tag, "_accept"}, 32'(got), 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
            acc = cyc;
        end
        req_valid = 1'b0;
    endtask

    // Wait (bounded) for a response and compare it with the scoreboard head
    task automatic wait_rsp(input string tag);
        bit   seen = 0;
        int   extra = 0;
        exp_t e = '{rdata: 32'h0, err: 1'b0, rel: 0};
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1) begin
                seen = 1;
                check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) e = sb.pop_front();
                check({tag, "_rdata"}, rsp_rdata_o, e.rdata);
                check({tag, "_err"}, 32'(rsp_err_o), 32'(e.err));
                check({tag, "_latency"}, 32'(cyc - acc + 1), 32'(e.rel));
                check({tag, "_ready_in_resp"}, 32'(req_ready_o), 32'd0);
            end
        end
        check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) extra++;
            if (i == 0) check({tag, "_ready_after"}, 32'(req_ready_o), 32'd1);
        end
        check({tag, "_single_pulse"}, 32'(extra), 32'd0);
        check({tag, "_rdata_hold"}, rsp_rdata_o, e.rdata);
        check({tag, "_err_hold"}, 32'(rsp_err_o), 32'(e.err));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int s_aw, s_w, s_b, s_ar, s_awv, s_wv, s_arv, s_wafter, s_unst;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awvalid", 32'(awvalid_o), 32'd0);
        check("rst_wvalid", 32'(wvalid_o), 32'd0);
        check("rst_arvalid", 32'(arvalid_o), 32'd0);
        check("rst_bready", 32'(bready_o), 32'd0);
        check("rst_rready", 32'(rready_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        check("rst_awaddr", awaddr_o, 32'h0);
        check("rst_araddr", araddr_o, 32'h0);
        check("rst_wdata", wdata_o, 32'h0);
        check("rst_wstrb", 32'(wstrb_o), 32'h0);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready_o), 32'd1);

        // Zero-wait write
        s_aw = aw_hs_n; s_w = w_hs_n; s_b = b_hs_n;
        sb.push_back('{rdata: 32'h0, err: 1'b0, rel: 3});
        issue("wr0", 1'b1, 32'h2000_0000, 32'h0001_0003, 4'hF);
        @(negedge clk);
        check("wr0_awvalid_c1", 32'(awvalid_o), 32'd1);
        check("wr0_wvalid_c1", 32'(wvalid_o), 32'd1);
        check("wr0_awaddr", awaddr_o, 32'h2000_0000);
        check("wr0_wdata", wdata_o, 32'h0001_0003);
        check("wr0_wstrb", 32'(wstrb_o), 32'hF);
        check("wr0_awprot", 32'(awprot_o), 32'd0);
        check("wr0_arvalid", 32'(arvalid_o), 32'd0);
        wait_rsp("wr0");
        check("wr0_aw_count", 32'(aw_hs_n - s_aw), 32'd1);
        check("wr0_w_count", 32'(w_hs_n - s_w), 32'd1);
        check("wr0_b_count", 32'(b_hs_n - s_b), 32'd1);
        check("wr0_aw_cycle", 32'(aw_hs_cyc - acc), 32'd1);
        check("wr0_b_cycle", 32'(b_hs_cyc - acc), 32'd2);

        // W accepted two cycles before AW
        aw_dly = 2;
        s_aw = aw_hs_n; s_b = b_hs_n; s_wafter = w_after; s_unst = aw_unstable;
        sb.push_back('{rdata: 32'h0, err: 1'b0, rel: 5});
        issue("wr1", 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'h3);
        wait_rsp("wr1");
        check("wr1_w_cycle", 32'(w_hs_cyc - acc), 32'd1);
        check("wr1_aw_cycle", 32'(aw_hs_cyc - acc), 32'd3);
        check("wr1_wvalid_dropped", 32'(w_after - s_wafter), 32'd0);
        check("wr1_awaddr_stable", 32'(aw_unstable - s_unst), 32'd0);
        check("wr1_aw_count", 32'(aw_hs_n - s_aw), 32'd1);
        check("wr1_b_count", 32'(b_hs_n - s_b), 32'd1);
        check("wr1_awaddr_seen", aw_addr_seen, 32'h2000_0010);
        check("wr1_wdata_seen", w_data_seen, 32'hDEAD_BEEF);
        check("wr1_wstrb_seen", 32'(w_strb_seen), 32'h3);
        aw_dly = 0;

        // UART read
        rdata_cfg = 32'h0000_000A; rresp_cfg = RESP_OKAY;
        s_ar = ar_hs_n;
        sb.push_back('{rdata: 32'h0000_000A, err: 1'b0, rel: 3});
        issue("rd0", 1'b0, 32'h2000_0004, 32'h0, 4'h0);
        wait_rsp("rd0");
        check("rd0_ar_count", 32'(ar_hs_n - s_ar), 32'd1);
        check("rd0_ar_cycle", 32'(ar_hs_cyc - acc), 32'd1);
        check("rd0_araddr_seen", ar_addr_seen, 32'h2000_0004);

        // Decode misses: no bus activity, error answered in cycle 1
        s_awv = aw_vld_n; s_wv = w_vld_n; s_arv = ar_vld_n;
        sb.push_back('{rdata: 32'h0, err: 1'b1, rel: 1});
        issue("miss_rd", 1'b0, 32'h3000_0000, 32'h0, 4'h0);
        wait_rsp("miss_rd");
        sb.push_back('{rdata: 32'h0, err: 1'b1, rel: 1});
        issue("miss_wr", 1'b1, 32'h1FFF_FFFC, 32'hCAFE_F00D, 4'hF);
        wait_rsp("miss_wr");
        check("miss_no_arvalid", 32'(ar_vld_n - s_arv), 32'd0);
        check("miss_no_awvalid", 32'(aw_vld_n - s_awv), 32'd0);
        check("miss_no_wvalid", 32'(w_vld_n - s_wv), 32'd0);

        // Top of the window still hits
        rdata_cfg = 32'h0000_55AA;
        sb.push_back('{rdata: 32'h0000_55AA, err: 1'b0, rel: 3});
        issue("rd_top", 1'b0, 32'h2FFF_FFFC, 32'h0, 4'h0);
        wait_rsp("rd_top");

        // Read with SLVERR and slow R
        rdata_cfg = 32'h1234_5678; rresp_cfg = RESP_SLVERR; r_dly = 2;
        sb.push_back('{rdata: 32'h1234_5678, err: 1'b1, rel: 5});
        issue("rd_err", 1'b0, 32'h2000_0008, 32'h0, 4'h0);
        wait_rsp("rd_err");
        rresp_cfg = RESP_OKAY; r_dly = 0;

        // Write with DECERR, slow W and slow B
        bresp_cfg = RESP_DECERR; w_dly = 1; b_dly = 1;
        sb.push_back('{rdata: 32'h0, err: 1'b1, rel: 5});
        issue("wr_err", 1'b1, 32'h2000_0020, 32'h0000_00FF, 4'h1);
        wait_rsp("wr_err");
        bresp_cfg = RESP_OKAY; w_dly = 0; b_dly = 0;

        // Reset in the middle of a stalled write
        aw_dly = 1000;
        issue("rst_mid", 1'b1, 32'h2000_0030, 32'h1111_2222, 4'hF);
        @(negedge clk);
        check("rst_mid_awvalid_before", 32'(awvalid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_awvalid_async", 32'(awvalid_o), 32'd0);
        check("rst_mid_wvalid_async", 32'(wvalid_o), 32'd0);
        check("rst_mid_ready_low", 32'(req_ready_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        aw_dly = 0;
        @(posedge clk);
        #1;
        check("rst_mid_ready_after", 32'(req_ready_o), 32'd1);
        check("rst_mid_no_rsp", 32'(rsp_valid_o), 32'd0);
        check("rst_mid_awvalid_after", 32'(awvalid_o), 32'd0);

        // Recovery read after reset
        rdata_cfg = 32'h0000_0077;
        sb.push_back('{rdata: 32'h0000_0077, err: 1'b0, rel: 3});
        issue("rd_post", 1'b0, 32'h2000_0004, 32'h0, 4'h0);
        wait_rsp("rd_post");

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
